// File: rtl/vend_session_ctrl.sv
// Vending session controller: coin credit accumulation, round-robin product grant,
// single dispense per session, and half-unit change payout.
module vend_session_ctrl #(
    parameter int N_PROD     = 4,
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 10,
    parameter int CREDIT_W   = 4,
    parameter int TIMEOUT    = 255,
    localparam int IDW       = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                coin_half,
    input  logic                coin_one,
    input  logic                cancel,
    input  logic [N_PROD-1:0]   sel_req,
    output logic                disp_valid,
    output logic [IDW-1:0]      disp_id,
    input  logic                disp_ready,
    output logic                ret_valid,
    input  logic                ret_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_rej,
    output logic                busy
);

    localparam int IW1   = IDW + 1;
    localparam int CW1   = CREDIT_W + 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_DISPENSE,
        ST_CHANGE
    } state_t;

    state_t              state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [IDW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [TMR_W-1:0]    timer_reg, timer_next;
    logic [IDW-1:0]      disp_id_reg, disp_id_next;
    logic                disp_valid_reg, disp_valid_next;
    logic                ret_valid_reg, ret_valid_next;
    logic                coin_rej_reg, coin_rej_next;
    logic                busy_reg, busy_next;

    // Requests rotated so that position 0 is the product at rr_ptr.
    logic [N_PROD-1:0] rot_req;
    logic [IDW-1:0]    rot_idx [N_PROD];

    generate
        for (genvar gi = 0; gi < N_PROD; gi++) begin : g_rot
            logic [IW1-1:0] sum;
            assign sum          = {1'b0, rr_ptr_reg} + IW1'(gi);
            assign rot_idx[gi]  = (sum >= IW1'(N_PROD)) ? IDW'(sum - IW1'(N_PROD)) : IDW'(sum);
            assign rot_req[gi]  = sel_req[rot_idx[gi]];
        end
    endgenerate

    logic           grant_hit;
    logic [IDW-1:0] grant_id;
    logic [IW1-1:0] grant_p1;
    logic [IDW-1:0] grant_wrap;

    always_comb begin
        grant_hit = 1'b0;
        grant_id  = '0;
        for (int k = N_PROD - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                grant_hit = 1'b1;
                grant_id  = rot_idx[k];
            end
        end
    end

    assign grant_p1   = {1'b0, grant_id} + IW1'(1);
    assign grant_wrap = (grant_p1 >= IW1'(N_PROD)) ? '0 : IDW'(grant_p1);

    logic [CW1-1:0] coin_add;
    logic [CW1-1:0] credit_sum;
    logic           coin_any;
    logic           coin_fits;
    logic           cancel_go;
    logic           grant_go;
    logic           coin_ok;
    logic           open_state;

    assign coin_add   = CW1'({coin_one, coin_half});
    assign credit_sum = {1'b0, credit_reg} + coin_add;
    assign coin_any   = coin_half | coin_one;
    assign coin_fits  = (credit_sum <= CW1'(MAX_CREDIT));
    assign open_state = (state_reg == ST_IDLE) || (state_reg == ST_CREDIT);
    assign cancel_go  = (state_reg == ST_CREDIT) && cancel;
    assign grant_go   = (state_reg == ST_CREDIT) && !cancel && grant_hit &&
                        (credit_reg >= CREDIT_W'(PRICE));
    assign coin_ok    = coin_any && coin_fits && open_state && !cancel_go && !grant_go;

    always_comb begin
        state_next   = state_reg;
        credit_next  = credit_reg;
        rr_ptr_next  = rr_ptr_reg;
        timer_next   = timer_reg;
        disp_id_next = disp_id_reg;
        case (state_reg)
            ST_IDLE: begin
                if (coin_ok) begin
                    credit_next = credit_sum[CREDIT_W-1:0];
                    timer_next  = '0;
                    state_next  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (cancel_go) begin
                    timer_next = '0;
                    state_next = ST_CHANGE;
                end else if (grant_go) begin
                    credit_next  = credit_reg - CREDIT_W'(PRICE);
                    disp_id_next = grant_id;
                    rr_ptr_next  = grant_wrap;
                    timer_next   = '0;
                    state_next   = ST_DISPENSE;
                end else if (coin_ok) begin
                    credit_next = credit_sum[CREDIT_W-1:0];
                    timer_next  = '0;
                end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                    timer_next = '0;
                    state_next = ST_CHANGE;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            ST_DISPENSE: begin
                if (disp_valid_reg && disp_ready) begin
                    state_next = (credit_reg != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (ret_valid_reg && ret_ready) begin
                    credit_next = credit_reg - CREDIT_W'(1);
                    if (credit_reg == CREDIT_W'(1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with the state.
        disp_valid_next = (state_next == ST_DISPENSE);
        ret_valid_next  = (state_next == ST_CHANGE) && (credit_next != '0);
        busy_next       = (state_next == ST_DISPENSE) || (state_next == ST_CHANGE);
        coin_rej_next   = coin_any && !coin_ok;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg      <= ST_IDLE;
            credit_reg     <= '0;
            rr_ptr_reg     <= '0;
            timer_reg      <= '0;
            disp_id_reg    <= '0;
            disp_valid_reg <= 1'b0;
            ret_valid_reg  <= 1'b0;
            coin_rej_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            credit_reg     <= credit_next;
            rr_ptr_reg     <= rr_ptr_next;
            timer_reg      <= timer_next;
            disp_id_reg    <= disp_id_next;
            disp_valid_reg <= disp_valid_next;
            ret_valid_reg  <= ret_valid_next;
            coin_rej_reg   <= coin_rej_next;
            busy_reg       <= busy_next;
        end
    end

    assign disp_valid = disp_valid_reg;
    assign disp_id    = disp_id_reg;
    assign ret_valid  = ret_valid_reg;
    assign credit     = credit_reg;
    assign coin_rej   = coin_rej_reg;
    assign busy       = busy_reg;

endmodule
